// File: rtl/aq_djpeg_fbwr_pkg.sv
// Shared definitions for the decoder frame-buffer writer: FSM encoding,
// queue depth default and the 32-bit pixel word format.
package aq_djpeg_fbwr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } fbwr_state_e;

    localparam int FIFO_DEPTH_DEF = 16;
    localparam logic [7:0] PIX_PAD = 8'h00;

    function automatic logic [31:0] pack_pix(input logic [7:0] r, input logic [7:0] g,
                                             input logic [7:0] b);
        return {PIX_PAD, r, g, b};
    endfunction

endpackage

// File: rtl/aq_djpeg_fbwr_fifo.sv
// Show-ahead write queue holding {addr,data}; the caller guarantees push only
// when not full (or popping) and pop only when not empty.
module aq_djpeg_fbwr_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [63:0] wdata,
    input  logic        pop,
    output logic [63:0] rdata,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign rdata = mem[rp];
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);

endmodule

// File: rtl/aq_djpeg_fbwr.sv
// Frame-buffer writer: turns decoder pixel strobes into 32-bit memory writes,
// tracking frame completion, queue overflow and out-of-range pixels.
module aq_djpeg_fbwr
    import aq_djpeg_fbwr_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PixEnable,
    input  logic [15:0] PixWidth,
    input  logic [15:0] PixHeight,
    input  logic [15:0] PixX,
    input  logic [15:0] PixY,
    input  logic [7:0]  PixR,
    input  logic [7:0]  PixG,
    input  logic [7:0]  PixB,
    input  logic [31:0] FbBase,
    output logic        MemWrValid,
    input  logic        MemWrReady,
    output logic [31:0] MemWrAddr,
    output logic [31:0] MemWrData,
    output logic        Busy,
    output logic        FrameDone,
    output logic        Overflow,
    output logic        Range
);
    fbwr_state_e state;
    logic [31:0] base_l, total_l, rx_cnt;
    logic [15:0] width_l, height_l;

    // vld_pipe[0]: sampled pixel, vld_pipe[1]: address computed, pushed next edge
    logic [1:0]  vld_pipe;
    logic [15:0] s1_x, s1_y;
    logic [23:0] s1_rgb;
    logic [63:0] s2_ent, q_head;

    logic [15:0] cur_w, cur_h;
    logic in_range, start, take, accept, pop, push, push_fail, drained, q_full, q_empty;

    // The first pixel of a frame is judged against the live dimensions, since
    // the latched copies only update on that same edge.
    assign cur_w     = (state == ST_IDLE) ? PixWidth  : width_l;
    assign cur_h     = (state == ST_IDLE) ? PixHeight : height_l;
    assign in_range  = (PixX < cur_w) && (PixY < cur_h);
    assign start     = (state == ST_IDLE) && PixEnable && (PixWidth != '0) && (PixHeight != '0);
    assign take      = start || (PixEnable && (state == ST_ACTIVE) && (rx_cnt != total_l));
    assign accept    = take && in_range;
    assign pop       = ~q_empty && MemWrReady;
    assign push      = vld_pipe[1] && (~q_full || pop);
    assign push_fail = vld_pipe[1] && q_full && ~pop;
    assign drained   = (vld_pipe == '0) && q_empty;

    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[0], accept};
    end

    always_ff @(posedge clk) begin
        s1_x   <= PixX;
        s1_y   <= PixY;
        s1_rgb <= {PixR, PixG, PixB};
        s2_ent <= {base_l + ((32'(width_l) * 32'(s1_y) + 32'(s1_x)) << 2),
                   pack_pix(s1_rgb[23:16], s1_rgb[15:8], s1_rgb[7:0])};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            base_l    <= '0;
            width_l   <= '0;
            height_l  <= '0;
            total_l   <= '0;
            rx_cnt    <= '0;
            FrameDone <= 1'b0;
            Overflow  <= 1'b0;
            Range     <= 1'b0;
        end else begin
            FrameDone <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_ACTIVE;
                        base_l   <= FbBase;
                        width_l  <= PixWidth;
                        height_l <= PixHeight;
                        total_l  <= 32'(PixWidth) * 32'(PixHeight);
                        rx_cnt   <= 32'd1;
                        Overflow <= 1'b0;
                        Range    <= ~in_range;
                    end else if (PixEnable) begin
                        Range <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (PixEnable) begin
                        if (rx_cnt == total_l) Range <= 1'b1;
                        else begin
                            rx_cnt <= rx_cnt + 32'd1;
                            if (!in_range) Range <= 1'b1;
                        end
                    end
                    if (rx_cnt == total_l && drained) begin
                        state     <= ST_DONE;
                        FrameDone <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    if (PixEnable) Range <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
            if (push_fail) Overflow <= 1'b1;
        end
    end

    aq_djpeg_fbwr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (s2_ent),
        .pop   (pop),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty)
    );

    assign MemWrValid = ~q_empty;
    assign MemWrAddr  = q_empty ? 32'h0 : q_head[63:32];
    assign MemWrData  = q_empty ? 32'h0 : q_head[31:0];
    assign Busy       = (state != ST_IDLE) | (|vld_pipe) | ~q_empty;

endmodule
